// File: rtl/rom_arb_if.sv
// Bus bundle between two ROM requesters and rom_arb; the lock pins exist only
// when ROM_ARB_LOCK_EN is defined.
interface rom_arb_if;
  logic       ra_req0;
  logic [3:0] ra_addr0;
  logic       ra_ack0;
  logic [7:0] ra_data0;
  logic       ra_req1;
  logic [3:0] ra_addr1;
  logic       ra_ack1;
  logic [7:0] ra_data1;
  logic [3:0] ra_romaddr;
  logic [7:0] ra_romdata;
  logic       ra_busy;
`ifdef ROM_ARB_LOCK_EN
  logic       ra_lock0;
  logic       ra_lock1;
`endif

  modport master (
    output ra_req0, ra_addr0, ra_req1, ra_addr1, ra_romdata,
    input  ra_ack0, ra_data0, ra_ack1, ra_data1, ra_romaddr, ra_busy
`ifdef ROM_ARB_LOCK_EN
    , output ra_lock0, ra_lock1
`endif
  );

  modport slave (
    input  ra_req0, ra_addr0, ra_req1, ra_addr1, ra_romdata,
    output ra_ack0, ra_data0, ra_ack1, ra_data1, ra_romaddr, ra_busy
`ifdef ROM_ARB_LOCK_EN
    , input ra_lock0, ra_lock1
`endif
  );
endinterface

// File: rtl/rom_arb.sv
// Two-port round-robin arbiter in front of a shared 16x8 combinational ROM.
// Optional grant-hold (lock) feature enabled by defining ROM_ARB_LOCK_EN.
module rom_arb (
  input  logic      ra_clk,
  input  logic      ra_rst,
  rom_arb_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, SERVE = 1'b1} state_e;

  state_e     state_q, state_d;
  logic       sel_q, sel_d;
  logic       ptr_q, ptr_d;
  logic [3:0] addr_q, addr_d;
  logic       ack0_q, ack0_d, ack1_q, ack1_d;
  logic [7:0] data0_q, data0_d, data1_q, data1_d;
  logic       elig0, elig1, gnt_vld, gnt_port, hold_off;

`ifdef ROM_ARB_LOCK_EN
  logic [1:0] lcnt_q, lcnt_d;
  logic       lock_sel;
  assign lock_sel = sel_q ? bus.ra_lock1 : bus.ra_lock0;
  // A held pointer shows up as ptr == sel during the ack cycle; keep the other
  // port off for that one cycle so the locked port wins the following tie.
  assign hold_off = (ack0_q | ack1_q) & (ptr_q == sel_q);
`else
  assign hold_off = 1'b0;
`endif

  assign elig0    = bus.ra_req0 & ~ack0_q & ~(hold_off & sel_q);
  assign elig1    = bus.ra_req1 & ~ack1_q & ~(hold_off & ~sel_q);
  assign gnt_vld  = elig0 | elig1;
  assign gnt_port = (elig0 & elig1) ? ptr_q : elig1;

  always_ff @(posedge ra_clk) begin
    if (ra_rst) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      ptr_q   <= 1'b0;
      addr_q  <= 4'h0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      data0_q <= 8'h00;
      data1_q <= 8'h00;
`ifdef ROM_ARB_LOCK_EN
      lcnt_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
`ifdef ROM_ARB_LOCK_EN
      lcnt_q  <= lcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = SERVE;
      SERVE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    data0_d = data0_q;
    data1_d = data1_q;
`ifdef ROM_ARB_LOCK_EN
    lcnt_d  = lcnt_q;
`endif
    if (state_q == IDLE && gnt_vld) begin
      addr_d = gnt_port ? bus.ra_addr1 : bus.ra_addr0;
      sel_d  = gnt_port;
      ptr_d  = ~gnt_port;
`ifdef ROM_ARB_LOCK_EN
      if (gnt_port != sel_q) lcnt_d = 2'd0;
`endif
    end
    if (state_q == SERVE) begin
      if (sel_q) begin
        data1_d = bus.ra_romdata;
        ack1_d  = 1'b1;
      end else begin
        data0_d = bus.ra_romdata;
        ack0_d  = 1'b1;
      end
`ifdef ROM_ARB_LOCK_EN
      // Fourth consecutive locked grant leaves ptr on the other port.
      if (!lock_sel) begin
        lcnt_d = 2'd0;
      end else if (lcnt_q == 2'd3) begin
        lcnt_d = 2'd0;
      end else begin
        lcnt_d = lcnt_q + 2'd1;
        ptr_d  = sel_q;
      end
`endif
    end
  end

  always_comb begin
    bus.ra_busy    = (state_q == SERVE);
    bus.ra_romaddr = (state_q == SERVE) ? addr_q : 4'h0;
  end

  assign bus.ra_ack0  = ack0_q;
  assign bus.ra_ack1  = ack1_q;
  assign bus.ra_data0 = data0_q;
  assign bus.ra_data1 = data1_q;
endmodule

// File: tb/tb_rom_arb.sv
// Randomized bench for rom_arb: transaction-level reference model plus
// directed scenarios; lock scenario compiled only with ROM_ARB_LOCK_EN.
module tb_rom_arb;
  logic ra_clk = 1'b0;
  logic ra_rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  rom_arb_if bus();
  assign bus.ra_romdata = {~bus.ra_romaddr, bus.ra_romaddr};

  rom_arb dut (.ra_clk(ra_clk), .ra_rst(ra_rst), .bus(bus));

  always #5 ra_clk = ~ra_clk;

  // reference model: which port is being served (-1 = none)
  int         m_srv = -1;
  logic [3:0] m_addr = 4'h0;
  int         m_ptr = 0;
  bit         m_ack [2];
  logic [7:0] m_data [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rom(input logic [3:0] a);
    return {~a, a};
  endfunction

  task automatic step(input bit use_mdl);
    bit e0, e1;
    int w;
    @(posedge ra_clk);
    if (ra_rst) begin
      m_srv = -1; m_addr = 4'h0; m_ptr = 0;
      m_ack[0] = 0; m_ack[1] = 0; m_data[0] = 8'h00; m_data[1] = 8'h00;
    end else if (m_srv >= 0) begin
      m_data[m_srv] = rom(m_addr);
      m_ack[0] = (m_srv == 0);
      m_ack[1] = (m_srv == 1);
      m_srv = -1;
    end else begin
      e0 = bus.ra_req0 && !m_ack[0];
      e1 = bus.ra_req1 && !m_ack[1];
      m_ack[0] = 0; m_ack[1] = 0;
      w = (e0 && e1) ? m_ptr : e0 ? 0 : e1 ? 1 : -1;
      if (w >= 0) begin
        m_srv  = w;
        m_addr = (w == 1) ? bus.ra_addr1 : bus.ra_addr0;
        m_ptr  = 1 - w;
      end
    end
    #1;
    chk("ack_excl", 32'(bus.ra_ack0 & bus.ra_ack1), 32'd0);
    if (use_mdl) begin
      chk("ack0",    32'(bus.ra_ack0),    32'(m_ack[0]));
      chk("ack1",    32'(bus.ra_ack1),    32'(m_ack[1]));
      chk("data0",   32'(bus.ra_data0),   32'(m_data[0]));
      chk("data1",   32'(bus.ra_data1),   32'(m_data[1]));
      chk("busy",    32'(bus.ra_busy),    32'(m_srv >= 0));
      chk("romaddr", 32'(bus.ra_romaddr), (m_srv >= 0) ? 32'(m_addr) : 32'd0);
    end
  endtask

  task automatic do_reset();
    ra_rst = 1'b1;
    bus.ra_req0 = 1'b0;
    bus.ra_req1 = 1'b0;
    step(1);
    ra_rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int c0, c1;
    bus.ra_req0 = 1'b0; bus.ra_addr0 = 4'h0;
    bus.ra_req1 = 1'b0; bus.ra_addr1 = 4'h0;
`ifdef ROM_ARB_LOCK_EN
    bus.ra_lock0 = 1'b0; bus.ra_lock1 = 1'b0;
`endif
    #1;
    do_reset();
    chk("rst_data0", 32'(bus.ra_data0), 32'h00);
    chk("rst_busy",  32'(bus.ra_busy),  32'd0);

    // single port 0
    bus.ra_req0 = 1'b1; bus.ra_addr0 = 4'h3;
    step(1);
    bus.ra_req0 = 1'b0;
    chk("s0_busy", 32'(bus.ra_busy), 32'd1);
    chk("s0_romaddr", 32'(bus.ra_romaddr), 32'h3);
    step(1);
    chk("s0_ack0", 32'(bus.ra_ack0), 32'd1);
    chk("s0_data0", 32'(bus.ra_data0), 32'hC3);
    chk("s0_data1", 32'(bus.ra_data1), 32'h00);
    step(1);

    // tie right after reset goes to port 0
    do_reset();
    bus.ra_req0 = 1'b1; bus.ra_addr0 = 4'h1;
    bus.ra_req1 = 1'b1; bus.ra_addr1 = 4'hE;
    step(1);
    step(1);
    bus.ra_req0 = 1'b0;
    chk("tie_ack0", 32'(bus.ra_ack0), 32'd1);
    chk("tie_data0", 32'(bus.ra_data0), 32'hE1);
    step(1);
    step(1);
    bus.ra_req1 = 1'b0;
    chk("tie_ack1", 32'(bus.ra_ack1), 32'd1);
    chk("tie_data1", 32'(bus.ra_data1), 32'h1E);
    step(1);

    // continuous contention: 8 accesses
    do_reset();
    bus.ra_req0 = 1'b1; bus.ra_req1 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.ra_addr0 = 4'($urandom);
      bus.ra_addr1 = 4'($urandom);
      step(1);
      if (bus.ra_ack0) seq.push_back(0);
      if (bus.ra_ack1) seq.push_back(1);
    end
    bus.ra_req0 = 1'b0; bus.ra_req1 = 1'b0;
    chk("cont_n", 32'(seq.size()), 32'd8);
    c0 = 0; c1 = 0;
    foreach (seq[i]) begin
      chk("cont_order", 32'(seq[i]), 32'(i % 2));
      if (seq[i] == 0) c0++; else c1++;
    end
    chk("cont_c0", 32'(c0), 32'd4);
    chk("cont_c1", 32'(c1), 32'd4);
    step(1); step(1);

    // reset during SERVE aborts the access
    do_reset();
    bus.ra_req1 = 1'b1; bus.ra_addr1 = 4'h7;
    step(1);
    chk("rs_busy", 32'(bus.ra_busy), 32'd1);
    bus.ra_req1 = 1'b0; ra_rst = 1'b1;
    step(1);
    ra_rst = 1'b0;
    chk("rs_ack1", 32'(bus.ra_ack1), 32'd0);
    chk("rs_data1", 32'(bus.ra_data1), 32'h00);
    chk("rs_romaddr", 32'(bus.ra_romaddr), 32'h0);
    step(1);

    // address change mid-access
    bus.ra_req0 = 1'b1; bus.ra_addr0 = 4'h5;
    step(1);
    bus.ra_addr0 = 4'hA; bus.ra_req0 = 1'b0;
    step(1);
    chk("mid_data0", 32'(bus.ra_data0), 32'hA5);
    step(1);

`ifdef ROM_ARB_LOCK_EN
    // lock: port 0 held for 4 grants, then port 1
    begin
      int lseq[$];
      do_reset();
      bus.ra_lock0 = 1'b1;
      bus.ra_req0 = 1'b1; bus.ra_req1 = 1'b1;
      for (int i = 0; i < 60 && lseq.size() < 5; i++) begin
        step(0);
        if (bus.ra_ack0) lseq.push_back(0);
        if (bus.ra_ack1) lseq.push_back(1);
      end
      chk("lock_n", 32'(lseq.size()), 32'd5);
      foreach (lseq[i]) chk("lock_order", 32'(lseq[i]), (i < 4) ? 32'd0 : 32'd1);
      bus.ra_lock0 = 1'b0;
      bus.ra_req0 = 1'b0; bus.ra_req1 = 1'b0;
    end
`endif

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 400; i++) begin
      bus.ra_req0  = ($urandom_range(0, 3) != 0);
      bus.ra_req1  = ($urandom_range(0, 3) != 0);
      bus.ra_addr0 = 4'($urandom);
      bus.ra_addr1 = 4'($urandom);
      ra_rst       = ($urandom_range(0, 49) == 0);
      step(1);
    end
    ra_rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rom_arb.md
ROM_ARB -- requirements
Module: rom_arb

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ra_clk and ra_rst.
REQ-002 Ports SHALL be, clock and reset first:
- ra_clk  input  1  rising-edge clock
- ra_rst  input  1  synchronous active-high reset
- ra_req0  input  1  requester 0 read request, level
- ra_addr0  input  4  requester 0 ROM address
- ra_ack0  output  1  requester 0 read done, one-cycle pulse
- ra_data0  output  8  requester 0 read data, registered
- ra_req1  input  1  requester 1 read request, level
- ra_addr1  input  4  requester 1 ROM address
- ra_ack1  output  1  requester 1 read done, one-cycle pulse
- ra_data1  output  8  requester 1 read data, registered
- ra_romaddr  output  4  address to the shared 16x8 combinational ROM
- ra_romdata  input  8  data from the shared ROM
- ra_busy  output  1  high while a ROM access is in progress
- ra_lock0, ra_lock1  input  1  grant-hold requests (present only with ROM_ARB_LOCK_EN)

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and SERVE. A 1-bit served-port register (sel) and a 1-bit round-robin pointer (ptr) SHALL be kept.
REQ-004 In IDLE, the eligible request for port N SHALL be ra_reqN high and ra_ackN low. A request is ignored in its own ack cycle.
REQ-005 If only one port is eligible in IDLE, that port SHALL be granted. If both are eligible, the port equal to ptr SHALL be granted. If neither is eligible, the FSM SHALL stay in IDLE.
REQ-006 On a grant at edge t, the following SHALL take effect:
- ra_addrN is latched into an internal address register
- sel <= N
- ptr <= ~N
- state <= SERVE
REQ-007 In SERVE, ra_romaddr SHALL equal the latched address and ra_busy SHALL be 1. In IDLE, ra_romaddr SHALL be 4'h0 and ra_busy SHALL be 0.
REQ-008 At the end of the SERVE cycle, the following SHALL take effect and the FSM SHALL return to IDLE:
- ra_data[sel] <= ra_romdata
- ra_ack[sel] <= 1 for exactly one cycle
REQ-009 Latency SHALL be 2 cycles: req high at edge t, then ack and data valid in cycle t+2. Peak throughput SHALL be one access per 2 cycles. Alternating service SHALL occur when both ports request continuously.
REQ-010 ra_dataN SHALL hold its last value until the next ack on port N. The other port's data SHALL never change.
REQ-011 ra_addrN changing while in SERVE SHALL NOT affect the access in progress.
REQ-012 ra_ack0 and ra_ack1 SHALL never be high in the same cycle.

Reset
REQ-013 When ra_rst is sampled high, the following SHALL take effect at that edge:
- state = IDLE, sel = 0, ptr = 0, address register = 0
- ra_ack0 = ra_ack1 = 0
- ra_data0 = ra_data1 = 8'h00
- ra_busy = 0, ra_romaddr = 4'h0
REQ-014 A reset asserted during SERVE SHALL abort the access: no ack and no data update. After reset, the first tie SHALL go to port 0.

Configuration
REQ-015 The macro ROM_ARB_LOCK_EN SHALL select between two builds:
- Defined: ports ra_lock0 and ra_lock1 exist. If the served port's ra_lockN is high at the end of SERVE, ptr SHALL NOT advance and that port SHALL win the next tie. A lock counter SHALL force ptr to the other port after 4 consecutive locked grants to the same port. The counter SHALL clear on any grant to the other port and on reset.
- Undefined: no lock ports and pure round-robin per REQ-005/006.

Verification
REQ-016 The bench ROM model SHALL return {~addr, addr}. The bench SHALL cover:
- Single port 0: ra_req0=1, ra_addr0=4'h3 at edge 0 -> ra_busy=1 in cycle 1 with ra_romaddr=4'h3; ra_ack0=1 and ra_data0=8'hC3 in cycle 2; ra_data1 stays 8'h00.
- Tie after reset: both req at edge 0, ra_addr0=4'h1, ra_addr1=4'hE -> ra_ack0 at cycle 2 with 8'hE1; ra_ack1 at cycle 4 with 8'h1E; acks never overlap.
- Continuous contention for 8 accesses -> grants alternate 0,1,0,1,...; each port gets 4 acks.
- Reset in SERVE: ra_req1 granted, ra_rst=1 in the SERVE cycle -> no ra_ack1; all outputs at reset values next cycle.
- Address change mid-access: ra_addr0 changes 4'h5 to 4'hA during SERVE -> ra_data0=8'hA5.
- ROM_ARB_LOCK_EN build: ra_lock0=1 and both req held -> port 0 granted 4 times in a row, then port 1 granted.
